// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, 8 data bits LSB first, optional
// even/odd parity bit, stop bit. Every bit is held for CLKS_PER_BIT clocks.
//
// state    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | line idle at 1, waiting for TxD_start
// S_START  | driving the start bit (0)
// S_DATA   | driving data bits 0..7 from the shift register
// S_PARITY | driving the parity bit (never entered when PARITY = 0)
// S_STOP   | driving the stop bit (1)
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD,
    output logic       TxD_busy
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bit;

    // Frame sequencer; TxD and TxD_busy are registered so they only ever
    // change on a clock edge (or asynchronously on reset).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            TxD      <= 1'b1;
            TxD_busy <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    TxD      <= 1'b1;
                    TxD_busy <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (TxD_start) begin
                        shreg    <= TxD_data;
                        // Parity is fixed by the byte captured here, so later
                        // TxD_data activity cannot disturb it.
                        par_bit  <= (^TxD_data) ^ (PARITY == 2);
                        state    <= S_START;
                        TxD      <= 1'b0;
                        TxD_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                        TxD      <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                TxD   <= par_bit;
                            end else begin
                                state <= S_STOP;
                                TxD   <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            TxD     <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                        TxD      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                        TxD      <= 1'b1;
                        TxD_busy <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    TxD      <= 1'b1;
                    TxD_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (no/even/odd parity) at
// CLKS_PER_BIT=4, compared cycle by cycle against a frame-level model.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic [7:0] data = 8'h00;
    wire  [2:0] txd_v;
    wire  [2:0] busy_v;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .TxD_start(start_v[0]), .TxD_data(data),
        .TxD(txd_v[0]), .TxD_busy(busy_v[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .TxD_start(start_v[1]), .TxD_data(data),
        .TxD(txd_v[1]), .TxD_busy(busy_v[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut2 (
        .clk(clk), .rst(rst), .TxD_start(start_v[2]), .TxD_data(data),
        .TxD(txd_v[2]), .TxD_busy(busy_v[2]));

    // Instance d uses parity mode d.
    function automatic int frame_bits(input int p);
        return (p == 0) ? 10 : 11;
    endfunction

    // Line level of bit number idx of the frame carrying byte v.
    function automatic logic model_bit(input logic [7:0] v, input int p, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return v[idx-1];
        if (p != 0 && idx == 9) return (p == 1) ? (^v) : ~(^v);
        return 1'b1;
    endfunction

    task automatic drive_accept(input int d, input logic [7:0] v);
        @(negedge clk);
        data = v;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        data = 8'($urandom);
    endtask

    // Checks every busy cycle of a frame plus the idle cycle after it.
    // At cycle 'poke' a TxD_start pulse with pdata is injected mid-frame.
    task automatic expect_frame(input int d, input logic [7:0] v, input int poke,
                                input logic [7:0] pdata);
        int n;
        logic e;
        n = frame_bits(d) * CPB;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            e = model_bit(v, d, j / CPB);
            checks++;
            if (txd_v[d] !== e || busy_v[d] !== 1'b1) begin
                failures++;
                $display("FAIL frame dut%0d byte=%h cycle=%0d: TxD=%b busy=%b, expected TxD=%b busy=1",
                         d, v, j, txd_v[d], busy_v[d], e);
            end
            if (j == poke) begin
                data = pdata;
                start_v[d] = 1'b1;
                @(posedge clk);
                #1;
                start_v[d] = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (txd_v[d] !== 1'b1 || busy_v[d] !== 1'b0) begin
            failures++;
            $display("FAIL frame_end dut%0d byte=%h: TxD=%b busy=%b, expected TxD=1 busy=0",
                     d, v, txd_v[d], busy_v[d]);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        checks++;
        if (txd_v[d] !== 1'b1 || busy_v[d] !== 1'b0) begin
            failures++;
            $display("FAIL %s dut%0d: TxD=%b busy=%b, expected TxD=1 busy=0",
                     tag, d, txd_v[d], busy_v[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d, "reset_state");
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d, "after_release");
    endtask

    task automatic test_basic();
        drive_accept(0, 8'hA5);
        expect_frame(0, 8'hA5, -1, 8'h00);
    endtask

    task automatic test_parity();
        drive_accept(1, 8'h07);
        expect_frame(1, 8'h07, -1, 8'h00);
        drive_accept(2, 8'h07);
        expect_frame(2, 8'h07, -1, 8'h00);
    endtask

    task automatic test_extremes();
        for (int d = 0; d < 3; d++) begin
            drive_accept(d, 8'h00);
            expect_frame(d, 8'h00, -1, 8'h00);
            drive_accept(d, 8'hFF);
            expect_frame(d, 8'hFF, -1, 8'h00);
        end
    endtask

    task automatic test_ignore();
        drive_accept(0, 8'h3C);
        expect_frame(0, 8'h3C, 12, 8'hFF);
        for (int j = 0; j < 3 * CPB; j++) begin
            @(negedge clk);
            check_idle(0, "no_second_frame");
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        data = 8'h55;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        data = 8'hAA;
        expect_frame(0, 8'h55, -1, 8'h00);
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        expect_frame(0, 8'hAA, -1, 8'h00);
        @(negedge clk);
        check_idle(0, "after_back_to_back");
    endtask

    task automatic test_reset_midframe();
        drive_accept(0, 8'($urandom));
        // Data bit 3 is frame bit 4; stop one cycle into it.
        for (int j = 0; j < 4 * CPB + 2; j++) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_idle(0, "async_reset_abort");
        repeat (2) begin
            @(negedge clk);
            check_idle(0, "held_in_reset");
        end
        rst = 1'b1;
        @(negedge clk);
        check_idle(0, "no_resume");
        drive_accept(0, 8'h81);
        expect_frame(0, 8'h81, -1, 8'h00);
    endtask

    task automatic test_random();
        int d;
        int poke;
        logic [7:0] v;
        for (int i = 0; i < 12; i++) begin
            d = int'($urandom_range(0, 2));
            v = 8'($urandom);
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1;
            drive_accept(d, v);
            expect_frame(d, v, poke, 8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_extremes();
        test_ignore();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 The block SHALL take parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115200); legal values >= 2.
REQ-002 The block SHALL take parameter PARITY, default 0, selecting the parity bit: 0 = none, 1 = even, 2 = odd.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-005 The block SHALL have port TxD_start, input, 1 bit: request to send TxD_data, sampled on the rising clk edge.
REQ-006 The block SHALL have port TxD_data, input, 8 bits: the byte to send, captured when a request is accepted.
REQ-007 The block SHALL have port TxD, output, 1 bit: the serial line; idle level is 1.
REQ-008 The block SHALL have port TxD_busy, output, 1 bit: high while a frame is in progress.

Function
REQ-009 Frame format SHALL be: start bit 0; 8 data bits LSB first; a parity bit only when PARITY != 0; stop bit 1.
REQ-010 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY = 0.
REQ-011 A request SHALL be accepted only when the state is IDLE and TxD_start = 1 at a rising edge.
REQ-012 On acceptance, TxD_data SHALL be latched into a shift register, and the next state SHALL be START.
REQ-013 Later changes on TxD_data SHALL NOT affect the frame in progress.
REQ-014 TxD SHALL go to 0 and TxD_busy to 1 in the cycle right after acceptance (latency 1 clk).
REQ-015 Each bit SHALL hold TxD for exactly CLKS_PER_BIT cycles, timed by a baud counter of width ceil(log2(CLKS_PER_BIT)).
REQ-016 The baud counter SHALL clear at every bit boundary.
REQ-017 DATA SHALL use a 3-bit bit index, counting 0..7, and shift right at each bit boundary.
REQ-018 DATA SHALL exit after bit 7 to PARITY, or to STOP when PARITY = 0.
REQ-019 The parity bit SHALL be the XOR of the latched byte for even parity and its complement for odd parity, computed from the latched value.
REQ-020 After the last STOP cycle the state SHALL return to IDLE, with TxD = 1 and TxD_busy = 0 from the next cycle.
REQ-021 TxD_busy SHALL be high for exactly 10*CLKS_PER_BIT cycles when PARITY = 0, and 11*CLKS_PER_BIT cycles otherwise.
REQ-022 TxD_start asserted while TxD_busy = 1 SHALL be ignored; it is not queued and does not corrupt the frame.
REQ-023 TxD_start held high across the end of a frame SHALL be accepted in the first IDLE cycle, giving back-to-back frames with one idle cycle at TxD = 1.
REQ-024 TxD and TxD_busy SHALL be driven directly from registers, with no combinational path from inputs.
REQ-025 An illegal or unreachable state SHALL recover to IDLE on the next clock.

Reset
REQ-026 While rst = 0, the block SHALL asynchronously force: state IDLE, TxD = 1, TxD_busy = 0, baud counter 0, bit index 0, shift register 0.
REQ-027 A reset asserted mid-frame SHALL abort the frame immediately, with TxD = 1 within the same cycle and no partial resume after release.
REQ-028 After rst rises, the first rising edge with TxD_start = 1 SHALL be accepted normally.

Verification
REQ-029 Scenario: CLKS_PER_BIT=4, PARITY=0, send 8'hA5 -> TxD sequence 0,1,0,1,0,0,1,0,1,1 (4 clk each); TxD_busy high for 40 cycles.
REQ-030 Scenario: PARITY=1, send 8'h07 -> parity bit 1; with PARITY=2 the parity bit is 0; TxD_busy high for 44 cycles.
REQ-031 Scenario: during a frame of 8'h3C, pulse TxD_start with TxD_data=8'hFF -> the frame stays 8'h3C and no second frame follows.
REQ-032 Scenario: hold TxD_start=1 with 8'h55 then 8'hAA -> two back-to-back frames with exactly one idle cycle between them.
REQ-033 Scenario: assert rst low at data bit 3 -> TxD=1 and TxD_busy=0 without waiting for clk; after release, a new 8'h81 frame is correct.
REQ-034 Scenario: send 8'h00 and 8'hFF -> all-0 and all-1 data bits, with correct start and stop framing.
